// File: rtl/riscv_pkg.sv
// Shared core types: fetch/decode entry bundle and the canonical NOP.
package riscv_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

   typedef struct packed {
      logic [XLEN-1:0] instruction;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus_four;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch/decode queue.
// One write port, one asynchronous read port, no reset.
module fetch_queue_mem
   import riscv_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               i_we,
   input  logic [PW-1:0]      i_waddr,
   input  fetch_entry_t       i_wdata,
   input  logic [PW-1:0]      i_raddr,
   output fetch_entry_t       o_rdata
);

   fetch_entry_t r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction buffer: DEPTH-entry FIFO that
// shows a NOP to decode when empty and drops everything on flush.
module fetch_decode_queue #(
   parameter int              n         = 32,
   parameter int              DEPTH     = 4,
   parameter logic [n-1:0]    NOP_INSTR = riscv_pkg::NOP_INSTR
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         branch_instruction,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [n-1:0]                 instruction_next,
   input  logic [n-1:0]                 pc_next,
   input  logic [n-1:0]                 pc_plus_four_next,
   input  logic                         out_ready,
   output logic                         out_valid,
   output logic [n-1:0]                 instruction,
   output logic [n-1:0]                 pc,
   output logic [n-1:0]                 pc_plus_four,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   import riscv_pkg::*;

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] w_count_nxt;

   logic          w_push;
   logic          w_pop;
   fetch_entry_t  w_wdata;
   fetch_entry_t  w_rdata;

   // Handshakes depend only on registered count, so no
   // out_ready -> in_ready path exists.
   assign in_ready  = (r_count != FULL);
   assign out_valid = (r_count != '0);

   assign w_push = in_valid  & in_ready  & ~branch_instruction;
   assign w_pop  = out_ready & out_valid & ~branch_instruction;

   assign w_wdata = '{
      instruction:  instruction_next,
      pc:           pc_next,
      pc_plus_four: pc_plus_four_next
   };

   always_comb begin
      w_count_nxt = r_count;
      unique case ({w_push, w_pop})
         2'b10:   w_count_nxt = r_count + CW'(1);
         2'b01:   w_count_nxt = r_count - CW'(1);
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || branch_instruction) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         r_count <= w_count_nxt;
      end
   end

   fetch_queue_mem #(
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_push),
      .i_waddr (r_wr_ptr),
      .i_wdata (w_wdata),
      .i_raddr (r_rd_ptr),
      .o_rdata (w_rdata)
   );

   // Stale array contents stay hidden behind the NOP while empty.
   assign instruction  = out_valid ? w_rdata.instruction  : NOP_INSTR;
   assign pc           = out_valid ? w_rdata.pc           : '0;
   assign pc_plus_four = out_valid ? w_rdata.pc_plus_four : '0;

   assign count = r_count;

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: queue-based reference model,
// directed scenarios with literal expectations, then random traffic.
module tb_fetch_decode_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        br;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr_n;
   logic [31:0] pc_n;
   logic [31:0] ppf_n;
   logic        out_ready;
   logic        out_valid;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic [31:0] pc_plus_four;
   logic [2:0]  count;

   always #5 clk = ~clk;

   fetch_decode_queue #(
      .n         (32),
      .DEPTH     (DEPTH),
      .NOP_INSTR (32'h00000013)
   ) dut (
      .clk                (clk),
      .reset              (reset),
      .branch_instruction (br),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .instruction_next   (instr_n),
      .pc_next            (pc_n),
      .pc_plus_four_next  (ppf_n),
      .out_ready          (out_ready),
      .out_valid          (out_valid),
      .instruction        (instruction),
      .pc                 (pc),
      .pc_plus_four       (pc_plus_four),
      .count              (count)
   );

   typedef struct {
      logic [31:0] i;
      logic [31:0] p;
      logic [31:0] f;
   } ent_t;

   ent_t mq[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   chk_en = 0;

   function automatic void check(string name, logic [31:0] act,
                                 logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Reference: a plain FIFO queue, occupancy judged before the edge.
   always @(posedge clk) begin
      int   sz;
      ent_t tmp;
      sz = mq.size();
      if (reset === 1'b1 || br === 1'b1) begin
         mq.delete();
      end else begin
         if (out_ready && sz != 0) tmp = mq.pop_front();
         if (in_valid && sz != DEPTH) mq.push_back('{instr_n, pc_n, ppf_n});
      end
   end

   always @(negedge clk) begin
      int sz;
      if (chk_en) begin
         sz = mq.size();
         check("m_count", {29'b0, count}, sz);
         check("m_in_ready", {31'b0, in_ready}, {31'b0, sz != DEPTH});
         check("m_out_valid", {31'b0, out_valid}, {31'b0, sz != 0});
         if (sz != 0) begin
            check("m_instr", instruction, mq[0].i);
            check("m_pc", pc, mq[0].p);
            check("m_ppf", pc_plus_four, mq[0].f);
         end else begin
            check("m_instr_nop", instruction, 32'h00000013);
            check("m_pc_zero", pc, 32'h0);
            check("m_ppf_zero", pc_plus_four, 32'h0);
         end
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      br        = 1'b0;
      reset     = 1'b0;
   endtask

   task automatic push(input logic [31:0] p);
      in_valid = 1'b1;
      pc_n     = p;
      instr_n  = 32'hC0DE0000 ^ p;
      ppf_n    = p + 32'd4;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      br        = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      instr_n   = '0;
      pc_n      = '0;
      ppf_n     = '0;

      tick();
      chk_en = 1;
      tick();
      reset = 1'b0;
      check("rst_count", {29'b0, count}, 32'd0);
      check("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check("rst_in_ready", {31'b0, in_ready}, 32'd1);
      check("rst_instr", instruction, 32'h00000013);

      in_valid = 1'b1;
      instr_n  = 32'h00500093;
      pc_n     = 32'h0;
      ppf_n    = 32'h4;
      tick();
      in_valid = 1'b0;
      check("one_valid", {31'b0, out_valid}, 32'd1);
      check("one_instr", instruction, 32'h00500093);
      check("one_pc", pc, 32'h0);
      check("one_ppf", pc_plus_four, 32'h4);
      check("one_count", {29'b0, count}, 32'd1);
      pop();
      check("one_after_valid", {31'b0, out_valid}, 32'd0);
      check("one_after_nop", instruction, 32'h00000013);

      for (int k = 0; k < 4; k++) push(32'(4 * k));
      check("fill_count", {29'b0, count}, 32'd4);
      check("fill_in_ready", {31'b0, in_ready}, 32'd0);
      push(32'h99);
      check("fill_ignored_count", {29'b0, count}, 32'd4);
      check("fill_head_pc", pc, 32'h0);
      pop();
      pop();
      check("wrap_count2", {29'b0, count}, 32'd2);
      push(32'd16);
      push(32'd20);
      check("wrap_count4", {29'b0, count}, 32'd4);
      for (int k = 0; k < 4; k++) begin
         check("wrap_pop_pc", pc, 32'(8 + 4 * k));
         pop();
      end
      check("wrap_empty", {31'b0, out_valid}, 32'd0);

      push(32'h200);
      push(32'h204);
      out_ready = 1'b1;
      push(32'h208);
      out_ready = 1'b0;
      check("simul_count", {29'b0, count}, 32'd2);
      check("simul_head0", pc, 32'h204);
      pop();
      check("simul_head1", pc, 32'h208);
      check("simul_ppf1", pc_plus_four, 32'h20C);
      pop();

      push(32'h300);
      push(32'h304);
      push(32'h308);
      check("flush_pre_count", {29'b0, count}, 32'd3);
      br = 1'b1;
      push(32'h30C);
      br = 1'b0;
      check("flush_count", {29'b0, count}, 32'd0);
      check("flush_valid", {31'b0, out_valid}, 32'd0);
      check("flush_nop", instruction, 32'h00000013);
      check("flush_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      check("flush_no_ghost", {31'b0, out_valid}, 32'd0);

      push(32'h400);
      push(32'h404);
      push(32'h408);
      reset = 1'b1;
      br    = 1'b1;
      tick();
      idle();
      check("rstfl_count", {29'b0, count}, 32'd0);
      push(32'h100);
      check("rstfl_valid", {31'b0, out_valid}, 32'd1);
      check("rstfl_pc", pc, 32'h100);

      for (int c = 0; c < 3000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = (c < 1500) ? ($urandom_range(0, 2) == 0)
                                : ($urandom_range(0, 2) != 0);
         br        = ($urandom_range(0, 31) == 0);
         reset     = ($urandom_range(0, 99) == 0);
         instr_n   = $urandom;
         pc_n      = $urandom;
         ppf_n     = pc_n + 32'd4;
         tick();
      end
      idle();
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Parametrised fetch-to-decode instruction buffer that replaces the single-entry fetch/decode pipeline register in the RISC-V core. It holds up to DEPTH fetched {instruction, pc, pc_plus_four} entries in FIFO order, so fetch can run ahead while decode stalls. It presents a NOP to decode whenever it is empty, and discards all contents on a branch flush. It sits between the fetch stage (PC and instruction memory) and the decode stage.

## Interface
- n, 32, width of instruction and PC fields
- DEPTH, 4, number of entries; power of two, minimum 2
- NOP_INSTR, 32'h00000013, instruction presented when empty (addi x0,x0,0)
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk
- branch_instruction  in  1  flush request; empties the queue
- in_valid  in  1  fetch presents an entry
- in_ready  out  1  queue can accept; high iff count != DEPTH
- instruction_next, pc_next, pc_plus_four_next  in  n each  entry fields from fetch
- out_ready  in  1  decode consumes the head entry this cycle
- out_valid  out  1  head entry is valid; high iff count != 0
- instruction, pc, pc_plus_four  out  n each  head entry fields
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH-entry circular array, write pointer wr_ptr, read pointer rd_ptr, each $clog2(DEPTH) bits.
  - Pointers wrap modulo DEPTH naturally.
  - count is a separate register.
- Push occurs when in_valid && in_ready && !branch_instruction.
  - The entry is written at wr_ptr.
  - wr_ptr increments.
- Pop occurs when out_ready && out_valid && !branch_instruction.
  - rd_ptr increments.
- Count update: count += push − pop.
  - Simultaneous push and pop leaves count unchanged.
  - A push and pop in the same cycle are legal at any non-full, non-empty occupancy.
- Full (count == DEPTH):
  - in_ready = 0.
  - No write occurs even if in_valid is high.
  - A pop that cycle does not enable a same-cycle push; there is no combinational path from out_ready to in_ready.
- Empty (count == 0):
  - out_valid = 0.
  - instruction = NOP_INSTR, pc = 0, pc_plus_four = 0.
  - out_ready is ignored.
- Flush (branch_instruction = 1):
  - Next cycle: count = 0, wr_ptr = rd_ptr = 0.
  - Any same-cycle push and pop are discarded.
  - Flush has priority over push and pop.
- Reset has priority over flush:
  - Reset forces count = 0 and both pointers to 0.
  - Array contents need not be cleared.
- Non-empty outputs: instruction, pc and pc_plus_four are driven from array[rd_ptr]. The output mux is the only combinational logic from state to outputs.

## Timing
- Reset values: in_ready = 1, out_valid = 0, count = 0, instruction = 32'h00000013, pc = 0, pc_plus_four = 0.
- Latency: an entry pushed in cycle t is visible at the outputs with out_valid = 1 in cycle t+1 if the queue was empty. There is no same-cycle bypass.
- in_ready and out_valid are functions of registered count only.
- Flush asserted in cycle t: outputs show NOP and out_valid = 0 from cycle t+1. in_ready = 1 from t+1.
- Reset asserted mid-stream: the same as flush. The queue is empty on the cycle after the reset edge.
- Throughput: 1 push and 1 pop per cycle sustained.

## Structure
- Shared package riscv_pkg holds:
  - the NOP_INSTR constant (32'h00000013);
  - typedef struct packed fetch_entry_t {instruction, pc, pc_plus_four}, sized by n = 32.
- One sub-module is natural: fetch_queue_mem. It is a DEPTH × entry register array with one write port and one asynchronous read port, and no reset.
- fetch_decode_queue itself contains the pointers, count, handshake logic and NOP mux.

## Test plan
- Reset sequence: assert reset for 2 cycles, then release. Required: count = 0, out_valid = 0, in_ready = 1, instruction = 32'h00000013.
- Single entry: push {32'h00500093, pc = 32'h0, pc_plus_four = 32'h4} with out_ready = 0.
  - Next cycle: out_valid = 1, instruction = 32'h00500093, pc = 0, pc_plus_four = 4, count = 1.
  - Assert out_ready for 1 cycle. Afterwards: out_valid = 0, output = NOP.
- Fill and wrap (DEPTH = 4):
  - Push 4 entries with pc = 0, 4, 8, 12 while out_ready = 0. Then count = 4 and in_ready = 0. A 5th in_valid is ignored.
  - Pop 2 and push pc = 16, 20. Pops then return pc = 8, 12, 16, 20 in order, and pointers have wrapped.
- Simultaneous push and pop at count = 2: count stays 2 and ordering is preserved.
- Flush with count = 3 and in_valid = 1 in the same cycle: next cycle count = 0, out_valid = 0, output = NOP. The flush-cycle entry never appears.
- Reset asserted with count = 3 and branch_instruction = 1: next cycle count = 0. Then push pc = 32'h100, which appears one cycle later.
